// File: rtl/phase_clkgen.sv
// phase_clkgen: programmable multi-phase clock generator.
// A period counter runs 0..div-1. Each phase output is high for the first
// div>>1 counts after its own offset. A new divide ratio and offsets are
// held in a shadow register and applied only on a period boundary, so the
// outputs never change shape in the middle of a period.
// Config handshake: a request is taken when cfg_valid and cfg_ready are both
// high on a rising edge. cfg_ready stays low from that edge until the edge
// that applies the request. A rejected request never lowers cfg_ready; it
// only produces a one-cycle cfg_err pulse.
module phase_clkgen #(
    parameter int                          DIV_W        = 8,
    parameter int                          NUM_PHASE    = 3,
    parameter int                          DEF_DIV      = 10,
    parameter logic [NUM_PHASE*DIV_W-1:0]  DEF_PHASE    = 24'h03_07_00,
    parameter int                          LOCK_PERIODS = 2
) (
    input  logic                         CLK125M,
    input  logic                         io_asyncReset,
    input  logic                         en,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [DIV_W-1:0]             cfg_div,
    input  logic [NUM_PHASE*DIV_W-1:0]   cfg_phase,
    output logic                         cfg_err,
    output logic [NUM_PHASE-1:0]         clk_out,
    output logic                         running,
    output logic                         locked
);

    localparam int               LCK_W    = $clog2(LOCK_PERIODS + 2);
    localparam logic [LCK_W-1:0] LOCK_MAX = LCK_W'(LOCK_PERIODS);

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [DIV_W-1:0]             cnt;
    logic [DIV_W-1:0]             div_r;
    logic [NUM_PHASE*DIV_W-1:0]   off_r;
    logic [DIV_W-1:0]             sh_div;
    logic [NUM_PHASE*DIV_W-1:0]   sh_off;
    logic                         pending;
    logic [LCK_W-1:0]             per_cnt;
    logic [NUM_PHASE-1:0]         target;
    logic [DIV_W:0]               hi_ext;
    logic                         wrap;
    logic                         start;
    logic                         cfg_acc;
    logic                         cfg_ok;
    logic                         apply;

    assign wrap    = (state != ST_STOP) && (cnt == div_r - DIV_W'(1));
    assign start   = (state == ST_STOP) && en;
    assign cfg_acc = cfg_valid && !pending;
    // In STOP there is no period to protect, so a pending config applies at once.
    assign apply   = pending && ((state == ST_STOP) || wrap);
    assign hi_ext  = {2'b00, div_r[DIV_W-1:1]};

    assign cfg_ready = !pending;
    assign running   = (state != ST_STOP);
    assign locked    = (state == ST_RUN) && (per_cnt == LOCK_MAX);

    // Validate a requested configuration: ratio at least 2, every offset inside the period.
    always_comb begin
        cfg_ok = (cfg_div >= DIV_W'(2));
        for (int k = 0; k < NUM_PHASE; k++) begin
            if (cfg_phase[k*DIV_W +: DIV_W] >= cfg_div) begin
                cfg_ok = 1'b0;
            end
        end
    end

    // Per-phase waveform target: ((cnt - off_k) mod div) < div/2, modulus without a divider.
    always_comb begin
        target = '0;
        for (int k = 0; k < NUM_PHASE; k++) begin
            if (state != ST_STOP) begin
                if (cnt >= off_r[k*DIV_W +: DIV_W]) begin
                    target[k] = (({1'b0, cnt} - {1'b0, off_r[k*DIV_W +: DIV_W]}) < hi_ext);
                end else begin
                    target[k] = (({1'b0, cnt} + {1'b0, div_r}
                                  - {1'b0, off_r[k*DIV_W +: DIV_W]}) < hi_ext);
                end
            end
        end
    end

    // Run-state next-state logic; stopping always waits for the end of a period.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: begin
                if (en) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_nxt = wrap ? ST_STOP : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (en)        state_nxt = ST_RUN;
                else if (wrap) state_nxt = ST_STOP;
            end
            default: state_nxt = ST_STOP;
        endcase
    end

    // State register.
    always_ff @(posedge CLK125M or posedge io_asyncReset) begin
        if (io_asyncReset) state <= ST_STOP;
        else               state <= state_nxt;
    end

    // Counter, registered outputs, shadow config and lock period counter.
    always_ff @(posedge CLK125M or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            cnt     <= '0;
            div_r   <= DIV_W'(DEF_DIV);
            off_r   <= DEF_PHASE;
            sh_div  <= DIV_W'(DEF_DIV);
            sh_off  <= DEF_PHASE;
            pending <= 1'b0;
            per_cnt <= '0;
            clk_out <= '0;
            cfg_err <= 1'b0;
        end else begin
            if ((state == ST_STOP) || wrap) cnt <= '0;
            else                             cnt <= cnt + DIV_W'(1);

            // Entering STOP forces the outputs low instead of the last target.
            clk_out <= (state_nxt == ST_STOP) ? '0 : target;

            cfg_err <= cfg_acc && !cfg_ok;

            if (apply) begin
                div_r   <= sh_div;
                off_r   <= sh_off;
                pending <= 1'b0;
            end else if (cfg_acc && cfg_ok) begin
                sh_div  <= cfg_div;
                sh_off  <= cfg_phase;
                pending <= 1'b1;
            end

            if (start || apply) begin
                per_cnt <= '0;
            end else if (wrap && (per_cnt != LOCK_MAX)) begin
                per_cnt <= per_cnt + LCK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_phase_clkgen.sv
// tb_phase_clkgen: directed plus random stimulus for phase_clkgen, checked
// against a behavioural period/offset model kept in the bench.
module tb_phase_clkgen;

    localparam int W     = 8;
    localparam int NP    = 3;
    localparam int LOCKP = 2;

    logic              CLK125M = 1'b0;
    logic              io_asyncReset = 1'b1;
    logic              en = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [W-1:0]      cfg_div = '0;
    logic [NP*W-1:0]   cfg_phase = '0;
    logic              cfg_ready;
    logic              cfg_err;
    logic [NP-1:0]     clk_out;
    logic              running;
    logic              locked;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model: 0 = stopped, 1 = running, 2 = finishing last period.
    int           m_state;
    int           m_cnt;
    int           m_div;
    int           m_off [NP];
    int           m_sdiv;
    int           m_soff [NP];
    bit           m_pend;
    int           m_per;
    logic [NP-1:0] m_clk;
    bit           m_err;

    phase_clkgen #(
        .DIV_W(W), .NUM_PHASE(NP), .DEF_DIV(10),
        .DEF_PHASE(24'h03_07_00), .LOCK_PERIODS(LOCKP)
    ) dut (
        .CLK125M(CLK125M),
        .io_asyncReset(io_asyncReset),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div(cfg_div),
        .cfg_phase(cfg_phase),
        .cfg_err(cfg_err),
        .clk_out(clk_out),
        .running(running),
        .locked(locked)
    );

    // Clock
    always #4 CLK125M = ~CLK125M;

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_div   = 10;
        m_off[0] = 0; m_off[1] = 7; m_off[2] = 3;
        m_sdiv  = 10;
        for (int k = 0; k < NP; k++) m_soff[k] = m_off[k];
        m_pend  = 0;
        m_per   = 0;
        m_clk   = '0;
        m_err   = 0;
    endtask

    // One rising edge of the reference: inputs as presented before the edge.
    task automatic model_edge();
        bit live;
        bit wrap;
        bit acc;
        bit ok;
        bit apply;
        int nstate;
        live  = (m_state != 0);
        wrap  = live && (m_cnt == m_div - 1);
        acc   = cfg_valid && !m_pend;
        ok    = (cfg_div >= 2);
        for (int k = 0; k < NP; k++)
            if (int'(cfg_phase[k*W +: W]) >= int'(cfg_div)) ok = 0;
        apply = m_pend && (!live || wrap);
        nstate = m_state;
        if (m_state == 0)      nstate = en ? 1 : 0;
        else if (m_state == 1) nstate = en ? 1 : (wrap ? 0 : 2);
        else                   nstate = en ? 1 : (wrap ? 0 : 2);
        for (int k = 0; k < NP; k++) begin
            if (live && nstate != 0)
                m_clk[k] = (((m_cnt - m_off[k] + m_div) % m_div) < (m_div / 2));
            else
                m_clk[k] = 1'b0;
        end
        m_cnt = (!live || wrap) ? 0 : m_cnt + 1;
        if ((m_state == 0 && nstate == 1) || apply) m_per = 0;
        else if (wrap && m_per < LOCKP)             m_per = m_per + 1;
        m_err = acc && !ok;
        if (apply) begin
            m_div = m_sdiv;
            for (int k = 0; k < NP; k++) m_off[k] = m_soff[k];
            m_pend = 0;
        end else if (acc && ok) begin
            m_sdiv = int'(cfg_div);
            for (int k = 0; k < NP; k++) m_soff[k] = int'(cfg_phase[k*W +: W]);
            m_pend = 1;
        end
        m_state = nstate;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic compare_all();
        check("clk_out",   32'(clk_out),   32'(m_clk));
        check("running",   32'(running),   32'(m_state != 0));
        check("locked",    32'(locked),    32'(m_state == 1 && m_per >= LOCKP));
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        check("cfg_err",   32'(cfg_err),   32'(m_err));
    endtask

    // Driver: one clock, advance the model, sample 1 ns after the edge.
    task automatic step();
        @(posedge CLK125M);
        model_edge();
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic send_cfg(input int d, input int o2, input int o1, input int o0);
        cfg_valid = 1'b1;
        cfg_div   = W'(d);
        cfg_phase = {W'(o2), W'(o1), W'(o0)};
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        while (m_cnt != v && n < 40) begin
            step();
            n++;
        end
        if (m_cnt != v) begin
            n_fail++;
            $display("FAIL wait_cnt: count %0d not reached, model count %0d", v, m_cnt);
        end
    endtask

    task automatic wait_idle_cfg();
        int n;
        n = 0;
        while (m_pend && n < 300) begin
            step();
            n++;
        end
        if (m_pend) begin
            n_fail++;
            $display("FAIL wait_cfg: pending config never applied, cfg_ready %0b", cfg_ready);
        end
    endtask

    // Reset, asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        io_asyncReset = 1'b1;
        #2;
        model_reset();
        check("rst_clk_out",   32'(clk_out),   32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_running",   32'(running),   32'd0);
        check("rst_locked",    32'(locked),    32'd0);
        check("rst_cfg_err",   32'(cfg_err),   32'd0);
        repeat (2) @(posedge CLK125M);
        #1;
        io_asyncReset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int lag [NP];
        lag[0] = 0; lag[1] = 7; lag[2] = 3;
        model_reset();

        // Reset release, default config, legacy 5/5 waveforms.
        #1;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            step();
            for (int k = 0; k < NP; k++) begin
                check("legacy_wave", 32'(clk_out[k]),
                      32'((c >= 2) && (((c - 2 - lag[k] + 100) % 10) < 5)));
            end
            if (c == 20) check("lock_before", 32'(locked), 32'd0);
            if (c == 21) check("lock_at_2nd", 32'(locked), 32'd1);
        end

        // Rejections: ratio below 2, then offset equal to ratio.
        wait_cnt(2);
        send_cfg(1, 0, 0, 0);
        check("rej_div1_err", 32'(cfg_err), 32'd1);
        step();
        check("rej_div1_pulse", 32'(cfg_err), 32'd0);
        send_cfg(6, 0, 6, 0);
        check("rej_off_err", 32'(cfg_err), 32'd1);
        check("rej_off_rdy", 32'(cfg_ready), 32'd1);
        repeat (12) step();

        // Mid-period reconfig to div 4.
        wait_cnt(4);
        send_cfg(4, 1, 2, 0);
        check("cfg4_ready_low", 32'(cfg_ready), 32'd0);
        wait_cnt(9);
        step();
        check("cfg4_ready_back", 32'(cfg_ready), 32'd1);
        check("cfg4_unlocked", 32'(locked), 32'd0);
        repeat (14) step();
        check("cfg4_relocked", 32'(locked), 32'd1);

        // Back to the legacy configuration.
        send_cfg(10, 3, 7, 0);
        wait_idle_cfg();
        repeat (12) step();

        // Enable drop at cnt 3: finish the period, then stop.
        wait_cnt(3);
        en = 1'b0;
        repeat (6) step();
        check("drain_running", 32'(running), 32'd1);
        wait_cnt(0);
        check("drain_stopped", 32'(running), 32'd0);
        check("drain_low", 32'(clk_out), 32'd0);
        repeat (3) step();
        en = 1'b1;
        repeat (12) step();

        // Enable back during drain: no gap.
        wait_cnt(3);
        en = 1'b0;
        wait_cnt(5);
        en = 1'b1;
        repeat (15) step();
        check("redrain_running", 32'(running), 32'd1);

        // Odd divide.
        send_cfg(5, 4, 2, 0);
        wait_idle_cfg();
        repeat (15) step();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0) begin
                int d;
                d = $urandom_range(0, 12);
                cfg_valid = 1'b1;
                cfg_div   = W'(d);
                cfg_phase = {W'($urandom_range(0, d)), W'($urandom_range(0, d)),
                             W'($urandom_range(0, d))};
            end else begin
                cfg_valid = 1'b0;
            end
            step();
        end
        cfg_valid = 1'b0;
        en = 1'b1;

        // Reset with a config pending.
        wait_idle_cfg();
        send_cfg(12, 8, 4, 0);
        wait_idle_cfg();
        wait_cnt(2);
        send_cfg(5, 1, 1, 1);
        check("pend_ready_low", 32'(cfg_ready), 32'd0);
        do_reset();
        en = 1'b1;
        repeat (25) step();
        check("post_rst_ready", 32'(cfg_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
